// File: rtl/border_scan.sv
`default_nettype none
// ============================================================================
// Module   : border_scan
// Purpose  : Raster-scan border generator for the convolution datapath.
//            After an accepted start it walks an m x m feature map one pixel
//            per accepted step, reporting the linear index, column/row and
//            border flags, plus the legacy 2-bit padding code.
//            Row/column counters replace the per-index multiply-compare.
// Ports    : clk     - clock, all state changes on the rising edge
//            rst     - synchronous active-high reset
//            go      - start request, sampled only while idle
//            step    - advance to the next pixel, honoured only while valid
//            matrix  - feature-map side length, latched on an accepted go
//            i       - linear pixel index (row*m + col)
//            col/row - current pixel coordinates
//            edges   - border flags {bottom, top, right, left}
//                      ("edge" is a reserved word, hence the plural)
//            prov    - legacy code: 11 left, 10 right, 00 interior
//            valid   - outputs describe a live pixel
//            done    - one-cycle pulse after the last pixel is consumed
// Revision : 1.0 - initial release
// ============================================================================
module border_scan #(
  parameter int ADDR_W = 10,
  parameter int DIM_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              step,
  input  logic [DIM_W-1:0]  matrix,
  output logic [ADDR_W-1:0] i,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic [3:0]        edges,
  output logic [1:0]        prov,
  output logic              valid,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_i_one   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DIM_W-1:0]  c_dim_one = {{(DIM_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [DIM_W-1:0]    r_m;
  logic [ADDR_W-1:0]   r_i;
  logic [DIM_W-1:0]    r_col;
  logic [DIM_W-1:0]    r_row;

  logic [DIM_W-1:0]    w_m_last;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_col_first;
  logic                w_row_first;
  logic                w_scan;

  // m is never 0 while scanning, so m-1 cannot underflow where it matters.
  assign w_m_last    = r_m - c_dim_one;
  assign w_col_last  = (r_col == w_m_last);
  assign w_row_last  = (r_row == w_m_last);
  assign w_col_first = (r_col == '0);
  assign w_row_first = (r_row == '0);
  assign w_scan      = (r_state == ST_SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_m     <= '0;
      r_i     <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A zero-size map has no pixels; the request is simply dropped.
          if (go && (matrix != '0)) begin
            r_m     <= matrix;
            r_i     <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (step) begin
            if (w_col_last && w_row_last) begin
              // Clear the counters on the way out so DONE and IDLE show 0.
              r_i     <= '0;
              r_col   <= '0;
              r_row   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_i <= r_i + c_i_one;
              if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + c_dim_one;
              end else begin
                r_col <= r_col + c_dim_one;
              end
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded only from registered state.
  assign i     = r_i;
  assign col   = r_col;
  assign row   = r_row;
  assign valid = w_scan;
  assign done  = (r_state == ST_DONE);
  assign edges = w_scan ? {w_row_last, w_row_first, w_col_last, w_col_first} : 4'b0000;

  // Left has priority over right so a 1x1 map reports the left code.
  always_comb begin
    prov = 2'b00;
    if (w_scan) begin
      if (w_col_first) begin
        prov = 2'b11;
      end else if (w_col_last) begin
        prov = 2'b10;
      end
    end
  end

endmodule
`default_nettype wire
